div_subshift_multi: RTL and testbench

// - Iterative restoring divider, signed/unsigned per operation, STEPS quotient bits resolved per clock.
// - valid/ready on input and output; one operation in flight; result held until consumed.
// - Drop-in arithmetic unit for CPU/accelerator datapaths needing div/rem with backpressure.

---
 rtl/div_subshift_multi.sv | 143 ++++++++++++++
 tb/tb_div_subshift_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_subshift_multi.sv
// Iterative restoring divider: signed/unsigned per operation, STEPS quotient bits per cycle.
// Optional feature macro DIV_ZERO_DETECT_EN: short-circuit divide-by-zero and flag it on div_zero.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// PREP  | operand magnitudes formed, partial remainder cleared
// ITER  | STEPS restoring steps per cycle, DATA_W/STEPS cycles
// FIX   | sign correction of quotient/remainder, results registered
// DONE  | result presented until out_ready
module div_subshift_multi #(
    parameter int DATA_W = 32,
    parameter int STEPS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero,
    output logic              busy
);
    localparam int ITERS = DATA_W / STEPS;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              dvd_neg_q, dvs_neg_q, dz_q;
    logic [DATA_W-1:0] dvd_q, dvs_q, dvs_mag_q;
    logic [DATA_W-1:0] rem_q, quo_q, rem_d, quo_d;
    logic [DATA_W-1:0] quotient_q, remainder_q;
    logic              div_zero_q, out_valid_q;

    // Combinational cone for one ITER cycle; quo_q starts as the dividend magnitude
    // and is shifted out into the remainder while quotient bits shift in.
    logic [DATA_W-1:0] r_v, q_v;
    logic [DATA_W:0]   r_sh, trial;

    always_comb begin
        r_v   = rem_q;
        q_v   = quo_q;
        r_sh  = '0;
        trial = '0;
        for (int s = 0; s < STEPS; s++) begin
            r_sh  = {r_v, q_v[DATA_W-1]};
            // r_sh < 2*divisor, so the top bit of the DATA_W+1 difference is a valid borrow
            trial = r_sh - {1'b0, dvs_mag_q};
            q_v   = {q_v[DATA_W-2:0], ~trial[DATA_W]};
            r_v   = trial[DATA_W] ? r_sh[DATA_W-1:0] : trial[DATA_W-1:0];
        end
        rem_d = r_v;
        quo_d = q_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            dz_q        <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dvs_mag_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        dvd_q     <= dividend;
                        dvs_q     <= divisor;
                        dvd_neg_q <= sign & dividend[DATA_W-1];
                        dvs_neg_q <= sign & divisor[DATA_W-1];
                        dz_q      <= DZ_EN && (divisor == '0);
                        state_q   <= S_PREP;
                    end
                end
                S_PREP: begin
                    quo_q     <= dvd_neg_q ? -dvd_q : dvd_q;
                    dvs_mag_q <= dvs_neg_q ? -dvs_q : dvs_q;
                    rem_q     <= '0;
                    cnt_q     <= dz_q ? '0 : CNT_W'(ITERS - 1);
                    state_q   <= dz_q ? S_FIX : S_ITER;
                end
                S_ITER: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) state_q <= S_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    if (dz_q) begin
                        quotient_q  <= '1;
                        remainder_q <= dvd_q;
                    end else begin
                        quotient_q  <= (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
                        remainder_q <= dvd_neg_q ? -rem_q : rem_q;
                    end
                    div_zero_q  <= dz_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_subshift_multi.sv
// Scoreboard bench for div_subshift_multi: one STEPS=1 and one STEPS=4 instance,
// expected results from a plain-arithmetic reference model.
module tb_div_subshift_multi;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int unsigned  lat;
        int unsigned  acc;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, sign = 1'b0;
    logic in_valid1 = 1'b0, in_valid4 = 1'b0, out_ready1 = 1'b1;
    logic ord4_man = 1'b1, bp_en = 1'b0, bp_rnd = 1'b1, out_ready4;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic in_ready1, out_valid1, dz1, busy1, in_ready4, out_valid4, dz4, busy4;
    logic [W-1:0] q1, r1, q4, r4;

    int ncmp = 0, nbad = 0;
    int unsigned cyc = 0;
    exp_t exp1[$], exp4[$];
    exp_t e1, e4;
    logic [W-1:0] last_q1 = '0, last_r1 = '0;
    bit pov1 = 0, pov4 = 0;

    assign out_ready4 = bp_en ? bp_rnd : ord4_man;

    div_subshift_multi #(.DATA_W(W), .STEPS(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1),
        .sign(sign), .dividend(dividend), .divisor(divisor), .out_valid(out_valid1),
        .out_ready(out_ready1), .quotient(q1), .remainder(r1), .div_zero(dz1), .busy(busy1));

    div_subshift_multi #(.DATA_W(W), .STEPS(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid4), .in_ready(in_ready4),
        .sign(sign), .dividend(dividend), .divisor(divisor), .out_valid(out_valid4),
        .out_ready(out_ready4), .quotient(q4), .remainder(r4), .div_zero(dz4), .busy(busy4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        bp_rnd = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, ncmp=%0d", ncmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        ncmp++;
        if (act !== expv) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb;
        e.dz = 1'b0; e.lat = 0; e.acc = 0;
        if (b == '0) begin
            e.r = a;
            e.q = (sg && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
`ifdef DIV_ZERO_DETECT_EN
            e.q  = 32'hFFFF_FFFF;
            e.dz = 1'b1;
`endif
        end else if (!sg) begin
            e.q = a / b;
            e.r = a % b;
        end else begin
            sa  = longint'(signed'(a));
            sb  = longint'(signed'(b));
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
        end
        return e;
    endfunction

    task automatic issue(input bit d4, input bit sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit push);
        exp_t e;
        int n;
        e = model(sg, a, b);
        e.lat = d4 ? 10 : 34;
`ifdef DIV_ZERO_DETECT_EN
        if (b == '0) e.lat = 2;
`endif
        @(posedge clk);
        #1;
        sign = sg; dividend = a; divisor = b;
        if (d4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(d4 ? in_ready4 : in_ready1) && n < 400);
        chk(d4 ? "s4_accept_wait" : "s1_accept_wait", d4 ? in_ready4 : in_ready1, 1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0; in_valid4 = 1'b0;
        e.acc = cyc;
        if (push) begin
            if (d4) exp4.push_back(e);
            else begin
                exp1.push_back(e);
                last_q1 = e.q; last_r1 = e.r;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp1.size() != 0 || exp4.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp1.size() + exp4.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_in_ready"},  {in_ready1, in_ready4},   2'b11);
        chk({nm, "_out_valid"}, {out_valid1, out_valid4}, 2'b00);
        chk({nm, "_busy"},      {busy1, busy4},           2'b00);
        chk({nm, "_div_zero"},  {dz1, dz4},               2'b00);
        chk({nm, "_q1_r1"},     {q1, r1},                 64'd0);
    endtask

    // Scoreboard monitor: outputs must match the queue head on every cycle out_valid is high.
    always @(negedge clk) begin
        if (rst_n && out_valid1) begin
            if (exp1.size() == 0) chk("s1_unexpected_valid", out_valid1, 0);
            else begin
                e1 = exp1[0];
                chk("s1_quotient",  q1,  e1.q);
                chk("s1_remainder", r1,  e1.r);
                chk("s1_div_zero",  dz1, e1.dz);
                chk("s1_in_ready_busy", {in_ready1, busy1}, 2'b01);
                if (!pov1) chk("s1_latency", 64'(cyc - e1.acc), 64'(e1.lat));
                if (out_ready1) void'(exp1.pop_front());
            end
        end
        pov1 = rst_n && out_valid1;
        if (rst_n && out_valid4) begin
            if (exp4.size() == 0) chk("s4_unexpected_valid", out_valid4, 0);
            else begin
                e4 = exp4[0];
                chk("s4_quotient",  q4,  e4.q);
                chk("s4_remainder", r4,  e4.r);
                chk("s4_div_zero",  dz4, e4.dz);
                chk("s4_in_ready_busy", {in_ready4, busy4}, 2'b01);
                if (!pov4) chk("s4_latency", 64'(cyc - e4.acc), 64'(e4.lat));
                if (out_ready4) void'(exp4.pop_front());
            end
        end
        pov4 = rst_n && out_valid4;
    end

    initial begin
        logic [W-1:0] a, b;
        bit sg;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(0, 0, 32'd100,        32'd7,          1);
        issue(0, 1, 32'hFFFF_FF9C,  32'd7,          1);
        issue(0, 1, 32'd100,        32'hFFFF_FFF9,  1);
        issue(0, 1, MIN,            32'hFFFF_FFFF,  1);
        issue(0, 0, MIN,            32'hFFFF_FFFF,  1);
        issue(0, 0, 32'h1234_5678,  32'd0,          1);
        issue(0, 1, 32'h1234_5678,  32'd0,          1);
        issue(0, 1, 32'hFFFF_FF9C,  32'd0,          1);
        issue(0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1);
        drain();

        // flush in ITER cycle 5: outputs keep the previous result
        issue(0, 0, 32'd1000, 32'd3, 0);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_ready_valid_busy", {in_ready1, out_valid1, busy1}, 3'b100);
        chk("flush_holds_result", {q1, r1}, {last_q1, last_r1});
        issue(0, 0, 32'd9, 32'd3, 1);
        drain();

        // async reset in ITER cycle 10
        issue(0, 1, 32'd1000, 32'd3, 0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midop_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(0, 0, 32'd9, 32'd3, 1);
        drain();

        // backpressure: result must be held with in_ready low for 20 cycles
        ord4_man = 1'b0;
        issue(1, 1, 32'd1000, 32'hFFFF_FFF9, 1);
        n = 0;
        while (!out_valid4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("s4_hold_valid_seen", out_valid4, 1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 ord4_man = 1'b1;
        drain();

        bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = MIN; b = '1; end
                2: b = 32'($urandom_range(1, 15));
                3: b = ~32'($urandom_range(0, 14));
                4: a = 32'($urandom_range(0, 1000));
                5: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            issue(1, sg, a, b, 1);
        end
        drain();
        bp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
